// File: rtl/cnn_core_seq.sv
// -----------------------------------------------------------------------------
// cnn_core_seq
//   Sequencer for one convolution layer pass through the CNN core. It walks
//   the valid output-window positions of an IW x IH map in raster order and
//   issues one core input-valid per window. Issue is metered by a credit
//   counter sized to the downstream result FIFO. Results returned by the core
//   are counted, and completion is signalled once every result is back.
//
// Ports
//   clk, reset_n     clock and asynchronous active-low reset
//   i_start          start a pass (IDLE only)
//   i_abort          abandon the pass from any state (highest priority)
//   i_win_ready      line buffer holds the window at the current (x,y)
//   i_core_valid     core produced one result
//   i_out_pop        downstream consumed one result (returns one credit)
//   o_soft_reset     soft-reset pulse to the core (CLEAR or abort)
//   o_in_valid       one-cycle input-valid per issued window
//   o_win_x/o_win_y  coordinates of the window being issued
//   o_busy           high in CLEAR, RUN and DRAIN
//   o_done           one-cycle pulse at pass completion
//   o_err            sticky protocol error, cleared on entry to CLEAR
//   o_res_cnt        results received in the current pass
//   All outputs are registered.
// -----------------------------------------------------------------------------
module cnn_core_seq #(
  parameter int IW      = 8,
  parameter int IH      = 8,
  parameter int KX      = 3,
  parameter int KY      = 3,
  parameter int CREDITS = 4,
  localparam int OX  = IW - KX + 1,
  localparam int OY  = IH - KY + 1,
  localparam int N   = OX * OY,
  localparam int XW  = (OX > 1) ? $clog2(OX) : 1,
  localparam int YW  = (OY > 1) ? $clog2(OY) : 1,
  localparam int NW  = $clog2(N + 1),
  localparam int CRW = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_win_ready,
  input  logic          i_core_valid,
  input  logic          i_out_pop,
  output logic          o_soft_reset,
  output logic          o_in_valid,
  output logic [XW-1:0] o_win_x,
  output logic [YW-1:0] o_win_y,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [NW-1:0] o_res_cnt
);

  localparam logic [NW-1:0]  N_L    = NW'(N);
  localparam logic [CRW-1:0] CR_L   = CRW'(CREDITS);
  localparam logic [XW-1:0]  X_LAST = XW'(OX - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d, win_x_q, win_x_d;
  logic [YW-1:0]  y_q, y_d, win_y_q, win_y_d;
  logic [NW-1:0]  issued_q, issued_d;
  logic [NW-1:0]  res_cnt_q, res_cnt_d;
  logic [CRW-1:0] credits_q, credits_d;
  logic           err_q, err_d;
  logic           soft_reset_q, soft_reset_d;
  logic           in_valid_q, in_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic          clear, issue, last_win, trk, full;
  logic          pop_ok, pop_bad, res_ok, res_bad;
  logic [NW-1:0] res_cnt_inc;

  // Per-cycle events. Counters are reinitialised on the way into CLEAR so
  // that they already read zero while CLEAR is visible on the outputs.
  always_comb begin
    clear    = (state_q == S_IDLE) && i_start && !i_abort;
    issue    = (state_q == S_RUN) && i_win_ready && (credits_q != '0) &&
               (issued_q != N_L) && !i_abort;
    last_win = (issued_q == N_L - NW'(1));
    trk      = (state_q != S_CLEAR);
    full     = (credits_q == CR_L);
    // A pop at full credits is legal only when an issue consumes one in the
    // same cycle; the two then cancel.
    pop_ok   = trk && i_out_pop && (!full || issue);
    pop_bad  = trk && i_out_pop && full && !issue;
    res_ok   = i_core_valid && (state_q inside {S_CLEAR, S_RUN, S_DRAIN}) &&
               (res_cnt_q != N_L);
    res_bad  = i_core_valid && !res_ok;
    res_cnt_inc = res_ok ? res_cnt_q + NW'(1) : res_cnt_q;
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state. Abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (issue && last_win) state_d = S_DRAIN;
      S_DRAIN: if (res_cnt_inc == N_L) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_abort) state_d = S_IDLE;
  end

  // FSM: outputs and datapath next values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    x_d       = x_q;
    y_d       = y_q;
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
    issued_d  = issued_q;
    credits_d = credits_q;
    res_cnt_d = res_cnt_q;
    err_d     = err_q;
    if (clear) begin
      x_d       = '0;
      y_d       = '0;
      issued_d  = '0;
      credits_d = CR_L;
      res_cnt_d = '0;
      err_d     = 1'b0;
    end else begin
      if (issue) begin
        issued_d = issued_q + NW'(1);
        win_x_d  = x_q;
        win_y_d  = y_q;
        // After the final window x and y keep their last values.
        if (!last_win) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      if (trk) begin
        if (issue && !pop_ok)      credits_d = credits_q - CRW'(1);
        else if (pop_ok && !issue) credits_d = credits_q + CRW'(1);
      end
      res_cnt_d = res_cnt_inc;
      err_d     = err_q | pop_bad | res_bad;
    end
    soft_reset_d = clear || i_abort;
    in_valid_d   = issue;
    busy_d       = state_d inside {S_CLEAR, S_RUN, S_DRAIN};
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      issued_q     <= '0;
      credits_q    <= CR_L;
      res_cnt_q    <= '0;
      err_q        <= 1'b0;
      soft_reset_q <= 1'b0;
      in_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      issued_q     <= issued_d;
      credits_q    <= credits_d;
      res_cnt_q    <= res_cnt_d;
      err_q        <= err_d;
      soft_reset_q <= soft_reset_d;
      in_valid_q   <= in_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_soft_reset = soft_reset_q;
  assign o_in_valid   = in_valid_q;
  assign o_win_x      = win_x_q;
  assign o_win_y      = win_y_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_res_cnt    = res_cnt_q;

endmodule

// File: tb/tb_cnn_core_seq.sv
// -----------------------------------------------------------------------------
// tb_cnn_core_seq
//   Bench for cnn_core_seq on a 4x4 map with a 3x3 kernel (2x2 windows).
//   Two instances share all inputs: dut_a has 4 credits, dut_b has 2; `sel`
//   picks which one the monitor observes. A small core model echoes each
//   o_in_valid as i_core_valid three cycles later and drops in-flight results
//   on soft reset. Expected window coordinates are queued in raster order when
//   a pass is started and popped as o_in_valid pulses appear.
// -----------------------------------------------------------------------------
module tb_cnn_core_seq;

  localparam int IW = 4, IH = 4, KX = 3, KY = 3;
  localparam int OX = IW - KX + 1;
  localparam int OY = IH - KY + 1;
  localparam int N  = OX * OY;
  localparam int XW = 1, YW = 1, NW = 3;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } coord_t;

  logic clk = 1'b0;
  logic reset_n;
  logic i_start, i_abort, i_win_ready, i_core_valid, i_out_pop;

  logic          a_soft, a_inv, a_busy, a_done, a_err;
  logic [XW-1:0] a_x;
  logic [YW-1:0] a_y;
  logic [NW-1:0] a_cnt;
  logic          b_soft, b_inv, b_busy, b_done, b_err;
  logic [XW-1:0] b_x;
  logic [YW-1:0] b_y;
  logic [NW-1:0] b_cnt;

  logic          sel;
  logic          m_soft, m_inv, m_busy, m_done, m_err;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [NW-1:0] m_cnt;

  assign m_soft = sel ? b_soft : a_soft;
  assign m_inv  = sel ? b_inv  : a_inv;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_err  = sel ? b_err  : a_err;
  assign m_x    = sel ? b_x    : a_x;
  assign m_y    = sel ? b_y    : a_y;
  assign m_cnt  = sel ? b_cnt  : a_cnt;

  cnn_core_seq #(.IW(IW), .IH(IH), .KX(KX), .KY(KY), .CREDITS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_win_ready(i_win_ready), .i_core_valid(i_core_valid), .i_out_pop(i_out_pop),
    .o_soft_reset(a_soft), .o_in_valid(a_inv), .o_win_x(a_x), .o_win_y(a_y),
    .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_res_cnt(a_cnt)
  );

  cnn_core_seq #(.IW(IW), .IH(IH), .KX(KX), .KY(KY), .CREDITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_win_ready(i_win_ready), .i_core_valid(i_core_valid), .i_out_pop(i_out_pop),
    .o_soft_reset(b_soft), .o_in_valid(b_inv), .o_win_x(b_x), .o_win_y(b_y),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_res_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  int       issues, results_seen, done_seen;
  bit       auto_pop, echo_en;
  logic [2:0] pipe;
  coord_t   exp_q[$];
  coord_t   exp_c;

  // Queue the expected raster order of one full pass.
  task automatic push_all();
    coord_t c;
    for (int yy = 0; yy < OY; yy++) begin
      for (int xx = 0; xx < OX; xx++) begin
        c.x = XW'(xx);
        c.y = YW'(yy);
        exp_q.push_back(c);
      end
    end
  endtask

  // One clock: let the posedge happen, observe at the negedge, then update
  // the core/downstream model inputs for the next edge.
  task automatic tick();
    logic rdy;
    rdy = i_win_ready;
    @(negedge clk);
    if (m_inv) begin
      issues++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got issue at (%0d,%0d) required none", m_x, m_y);
      end else begin
        exp_c = exp_q.pop_front();
        if ({m_x, m_y} !== {exp_c.x, exp_c.y}) begin
          errors++;
          $display("FAIL issue_coord: got (%0d,%0d) required (%0d,%0d)",
                   m_x, m_y, exp_c.x, exp_c.y);
        end
      end
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL issue_without_ready: got ready=%0b required 1", rdy);
      end
    end
    if (m_done) done_seen++;
    if (m_soft) pipe = '0;
    i_core_valid = echo_en & pipe[2];
    pipe         = {pipe[1:0], m_inv};
    if (i_core_valid) results_seen++;
    i_out_pop = auto_pop ? i_core_valid : 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_seen;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_seen != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic s);
    sel = s;
    reset_n = 1'b0;
    i_start = 0; i_abort = 0; i_win_ready = 0; i_core_valid = 0; i_out_pop = 0;
    auto_pop = 0; echo_en = 0; pipe = '0;
    exp_q.delete();
    issues = 0; results_seen = 0; done_seen = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_soft, a_inv, a_busy, a_done, a_err, a_x, a_y, a_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %b required all zero",
               {a_soft, a_inv, a_busy, a_done, a_err, a_x, a_y, a_cnt});
    end
    checks++;
    if ({b_soft, b_inv, b_busy, b_done, b_err, b_x, b_y, b_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %b required all zero",
               {b_soft, b_inv, b_busy, b_done, b_err, b_x, b_y, b_cnt});
    end
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (m_busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %0b required 0", m_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset(1'b0);
    auto_pop = 1; echo_en = 1; i_win_ready = 1;
    push_all();
    i_start = 1; tick(); i_start = 0;
    checks++;
    if (m_soft !== 1'b1 || m_busy !== 1'b1) begin
      errors++; $display("FAIL basic_clear: got soft=%0b busy=%0b required 1 1", m_soft, m_busy);
    end
    tick();
    checks++;
    if (m_soft !== 1'b0) begin
      errors++; $display("FAIL basic_soft_width: got %0b required 0", m_soft);
    end
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got timeout required done pulse"); end
    checks++;
    if (issues != N || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_issues: got %0d required %0d", issues, N);
    end
    checks++;
    if (m_cnt !== NW'(N) || m_err !== 1'b0) begin
      errors++; $display("FAIL basic_result: got cnt=%0d err=%0b required %0d 0", m_cnt, m_err, N);
    end
    tick();
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got done=%0b busy=%0b required 0 0", m_done, m_busy);
    end
    repeat (3) tick();
    checks++;
    if (m_cnt !== NW'(N) || issues != N) begin
      errors++; $display("FAIL basic_hold: got cnt=%0d issues=%0d required %0d %0d", m_cnt, issues, N, N);
    end
  endtask

  task automatic test_credit_stall();
    bit ok;
    do_reset(1'b1);
    echo_en = 1; i_win_ready = 1;
    push_all();
    i_start = 1; tick(); i_start = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (results_seen >= 2) begin ok = 1; break; end
    end
    checks++;
    if (!ok || issues != 2) begin
      errors++; $display("FAIL stall_first: got issues=%0d ok=%0b required 2 1", issues, ok);
    end
    repeat (3) tick();
    checks++;
    if (issues != 2) begin
      errors++; $display("FAIL stall_hold: got issues=%0d required 2", issues);
    end
    for (int p = 0; p < 2; p++) begin
      i_out_pop = 1; tick(); tick();
      checks++;
      if (issues != 3 + p) begin
        errors++; $display("FAIL stall_release: got issues=%0d required %0d", issues, 3 + p);
      end
      repeat (3) tick();
      checks++;
      if (issues != 3 + p) begin
        errors++; $display("FAIL stall_one_per_pop: got issues=%0d required %0d", issues, 3 + p);
      end
    end
    wait_done(30, ok);
    checks++;
    if (!ok || m_cnt !== NW'(N) || m_err !== 1'b0) begin
      errors++; $display("FAIL stall_done: got ok=%0b cnt=%0d err=%0b required 1 %0d 0", ok, m_cnt, m_err, N);
    end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    int d0;
    do_reset(1'b0);
    auto_pop = 1; echo_en = 1;
    push_all();
    i_start = 1; tick(); i_start = 0;
    d0 = done_seen;
    ok = 0;
    for (int c = 0; c < 60; c++) begin
      i_win_ready = (c % 3 == 0);
      tick();
      if (done_seen != d0) begin ok = 1; break; end
    end
    checks++;
    if (!ok || issues != N || exp_q.size() != 0) begin
      errors++; $display("FAIL toggle_done: got ok=%0b issues=%0d required 1 %0d", ok, issues, N);
    end
  endtask

  task automatic test_issue_pop_same();
    bit ok;
    do_reset(1'b1);
    echo_en = 1;
    push_all();
    i_start = 1; tick(); i_start = 0;
    tick();
    i_win_ready = 1; tick();
    checks++;
    if (issues != 1) begin errors++; $display("FAIL same_first: got %0d required 1", issues); end
    i_out_pop = 1; tick();
    checks++;
    if (issues != 2) begin errors++; $display("FAIL same_issue_pop: got %0d required 2", issues); end
    tick();
    checks++;
    if (issues != 3) begin errors++; $display("FAIL same_next_issue: got %0d required 3", issues); end
    repeat (3) tick();
    checks++;
    if (issues != 3) begin errors++; $display("FAIL same_credits_one: got %0d required 3", issues); end
    i_out_pop = 1; tick(); tick();
    wait_done(30, ok);
    checks++;
    if (!ok || issues != N || m_err !== 1'b0) begin
      errors++; $display("FAIL same_done: got ok=%0b issues=%0d err=%0b required 1 %0d 0", ok, issues, m_err, N);
    end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset(1'b0);
    auto_pop = 1; echo_en = 1; i_win_ready = 1;
    push_all();
    i_start = 1; tick(); i_start = 0;
    for (int i = 0; i < 20 && issues < 2; i++) tick();
    i_win_ready = 0;
    for (int i = 0; i < 20 && results_seen < 2; i++) tick();
    tick();
    checks++;
    if (m_cnt !== NW'(2) || issues != 2) begin
      errors++; $display("FAIL abort_pre: got cnt=%0d issues=%0d required 2 2", m_cnt, issues);
    end
    i_abort = 1; i_win_ready = 1; tick(); i_abort = 0;
    checks++;
    if (m_soft !== 1'b1 || m_busy !== 1'b0 || m_inv !== 1'b0 || m_cnt !== NW'(2)) begin
      errors++; $display("FAIL abort_state: got soft=%0b busy=%0b inv=%0b cnt=%0d required 1 0 0 2",
                         m_soft, m_busy, m_inv, m_cnt);
    end
    exp_q.delete();
    repeat (4) tick();
    checks++;
    if (issues != 2 || m_soft !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got issues=%0d soft=%0b required 2 0", issues, m_soft);
    end
    push_all();
    i_start = 1; tick(); i_start = 0;
    checks++;
    if (m_cnt !== '0 || m_soft !== 1'b1) begin
      errors++; $display("FAIL abort_restart: got cnt=%0d soft=%0b required 0 1", m_cnt, m_soft);
    end
    wait_done(40, ok);
    checks++;
    if (!ok || m_cnt !== NW'(N) || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_rerun: got ok=%0b cnt=%0d left=%0d required 1 %0d 0",
                         ok, m_cnt, exp_q.size(), N);
    end
  endtask

  task automatic test_errors();
    bit ok;
    do_reset(1'b0);
    auto_pop = 1; echo_en = 1; i_win_ready = 1;
    push_all();
    i_start = 1; tick(); i_start = 0;
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_pass: got timeout required done pulse"); end
    tick();
    auto_pop = 0;
    i_core_valid = 1; tick();
    checks++;
    if (m_err !== 1'b1 || m_cnt !== NW'(N)) begin
      errors++; $display("FAIL err_extra_valid: got err=%0b cnt=%0d required 1 %0d", m_err, m_cnt, N);
    end
    repeat (3) tick();
    checks++;
    if (m_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b required 1", m_err); end
    i_win_ready = 0;
    i_start = 1; tick(); i_start = 0;
    checks++;
    if (m_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b required 0", m_err); end
    tick();
    i_out_pop = 1; tick();
    checks++;
    if (m_err !== 1'b1) begin errors++; $display("FAIL err_pop_full: got %0b required 1", m_err); end
    i_abort = 1; tick(); i_abort = 0;
    tick();
    checks++;
    if (m_err !== 1'b1 || m_busy !== 1'b0) begin
      errors++; $display("FAIL err_after_abort: got err=%0b busy=%0b required 1 0", m_err, m_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_ready_toggle();
    test_issue_pop_same();
    test_abort();
    test_errors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_core_seq.md
Name: cnn_core_seq

Overview:
- Sequencer that drives one convolution layer pass through the CNN core.
- Walks the valid output-window positions of an IW x IH input map in raster order and issues one core input-valid per window (line buffer supplies the window data at the issued coordinates).
- Meters issue with a credit counter sized to the downstream result FIFO, counts results returned by the core, and signals completion.
- Sits between the layer-level control/line buffer and the core's valid/soft-reset inputs.

Parameters:
IW, 8, input feature map width in pixels
IH, 8, input feature map height in pixels
KX, 3, kernel width
KY, 3, kernel height
CREDITS, 4, result slots available downstream (1..15)
Derived (localparam): OX=IW-KX+1, OY=IH-KY+1, N=OX*OY, XW=clog2(OX) (min 1), YW=clog2(OY) (min 1), NW=clog2(N+1), CRW=clog2(CREDITS+1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_start  input  1  start a layer pass; honoured only in IDLE
i_abort  input  1  abandon current pass from any state
i_win_ready  input  1  line buffer holds the window at current (x,y)
i_core_valid  input  1  core output valid (one result per issued window)
i_out_pop  input  1  downstream consumed one result; returns one credit
o_soft_reset  output  1  soft reset pulse to core
o_in_valid  output  1  input-valid to core, one cycle per window
o_win_x  output  XW  window column of the current issue
o_win_y  output  YW  window row of the current issue
o_busy  output  1  high in CLEAR, RUN, DRAIN
o_done  output  1  one-cycle pulse at pass completion
o_err  output  1  sticky protocol error
o_res_cnt  output  NW  results received in current pass

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous, active-low. All outputs are registered.
- Reset values: state IDLE; all outputs 0; credits=CREDITS; issue/result counters 0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: on i_start go to CLEAR; otherwise stay.
- CLEAR (exactly 1 cycle):
  - o_soft_reset=1.
  - x, y, issued count and o_res_cnt set to 0; credits set to CREDITS; o_err cleared.
  - Next state RUN.
- RUN issue condition: i_win_ready && credits>0 && issued<N.
  - On issue, o_in_valid=1 on the next cycle, with o_win_x/o_win_y holding the coordinates of that window.
  - Then x++; when x==OX-1, x wraps to 0 and y++.
  - After issuing window N-1, go to DRAIN; x and y hold their last values.
- o_in_valid is 0 in every cycle without an issue. It is never high in IDLE, CLEAR, DRAIN or DONE, except for the registered pulse from the final RUN issue.
- Credits:
  - Issue decrements; i_out_pop increments.
  - Issue and pop in the same cycle leave credits unchanged.
  - A pop at credits==CREDITS is ignored and sets o_err.
  - Credits are tracked in every state except CLEAR.
- Results:
  - i_core_valid in CLEAR, RUN or DRAIN increments o_res_cnt.
  - i_core_valid when o_res_cnt==N, or in IDLE/DONE, sets o_err and does not count.
- DRAIN: when o_res_cnt reaches N (including the increment made this cycle), go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_res_cnt holds N until the next CLEAR.
- o_busy=1 in CLEAR, RUN and DRAIN.
- i_abort has priority over all transitions:
  - Next state IDLE; o_soft_reset=1 for one cycle; o_in_valid=0.
  - Counters and credits are left as-is; CLEAR reinitialises them.
  - i_abort while in IDLE also pulses o_soft_reset.
- i_start outside IDLE is ignored.
- Degenerate case: if N==1, the first issue goes directly to DRAIN.

Test Plan:
- IW=IH=4, KX=KY=3 (N=4), CREDITS=4, i_win_ready=1, core echoes each valid 3 cycles later, pops immediate -> o_soft_reset 1 cycle after start; 4 o_in_valid pulses with (x,y)=(0,0),(1,0),(0,1),(1,1); o_done pulse after the 4th result; o_res_cnt=4; o_err=0.
- Same config, CREDITS=2, no pops until the 2nd result arrives -> exactly 2 issues, then o_in_valid stalls; each pop releases exactly one further issue; o_done after 4 results.
- i_win_ready toggling 1,0,0,1,... -> issues occur only in ready cycles; coordinates never skip or repeat.
- Issue and pop in the same cycle at credits=1 -> credits stay 1 and the next issue proceeds.
- i_abort asserted during RUN after 2 issues -> next cycle state IDLE, o_soft_reset=1, o_busy=0, no further o_in_valid; a new i_start restarts at (0,0) with o_res_cnt=0.
- Extra i_core_valid after 4 results, and a pop at full credits -> o_err=1 and stays 1 until the next CLEAR; o_res_cnt stays 4.
